// File: rtl/hash_cmd_deserializer.sv
// Packs little-endian 32-bit AXI-Stream beats into one {op, key, data} command for the hash table.
// Packets of the wrong length or with a non-one-hot op are dropped, flagged and counted.
module hash_cmd_deserializer #(
    parameter int  KEY_WIDTH  = 2,
    parameter int  DATA_WIDTH = 32,
    parameter int  OP_WIDTH   = 3,
    localparam int CMD_WIDTH  = OP_WIDTH + KEY_WIDTH + DATA_WIDTH,
    localparam int NBEATS     = (CMD_WIDTH + 31) / 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          s_axis_tdata,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tlast,
    output logic                 s_axis_tready,
    output logic [CMD_WIDTH-1:0] cmd_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 err_short_o,
    output logic                 err_long_o,
    output logic                 err_op_o,
    output logic [15:0]          drop_cnt_o
);

    localparam int CNT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DISCARD = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          beat_cnt_q, beat_cnt_d;
    logic [NBEATS-1:0][31:0]   beats_q, beats_d, beats_new;
    logic [NBEATS*32-1:0]      flat_new;
    logic [CMD_WIDTH-1:0]      cmd_q, cmd_d;
    logic                      valid_q, valid_d;
    logic                      err_short_q, err_short_d;
    logic                      err_long_q, err_long_d;
    logic                      err_op_q, err_op_d;
    logic [15:0]               drop_cnt_q, drop_cnt_d;
    logic [OP_WIDTH-1:0]       op_new;
    logic                      op_ok;
    logic                      drop;

    // The incoming beat is merged combinationally so the final beat can be checked and loaded in one cycle.
    always_comb begin
        beats_new             = beats_q;
        beats_new[beat_cnt_q] = s_axis_tdata;
    end

    assign flat_new = beats_new;
    assign op_new   = flat_new[CMD_WIDTH-1 -: OP_WIDTH];
    assign op_ok    = (op_new != '0) && ((op_new & (op_new - OP_WIDTH'(1))) == '0);

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        beats_d     = beats_q;
        cmd_d       = cmd_q;
        valid_d     = valid_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        err_op_d    = 1'b0;
        drop        = 1'b0;
        drop_cnt_d  = drop_cnt_q;
        case (state_q)
            COLLECT: begin
                if (s_axis_tvalid) begin
                    beats_d = beats_new;
                    if (beat_cnt_q != LAST_BEAT) begin
                        if (s_axis_tlast) begin
                            err_short_d = 1'b1;
                            drop        = 1'b1;
                            beat_cnt_d  = '0;
                        end else begin
                            beat_cnt_d = beat_cnt_q + CNT_W'(1);
                        end
                    end else if (!s_axis_tlast) begin
                        err_long_d = 1'b1;
                        drop       = 1'b1;
                        state_d    = DISCARD;
                    end else if (!op_ok) begin
                        err_op_d   = 1'b1;
                        drop       = 1'b1;
                        beat_cnt_d = '0;
                    end else begin
                        cmd_d   = flat_new[CMD_WIDTH-1:0];
                        valid_d = 1'b1;
                        state_d = OUTPUT;
                    end
                end
            end
            DISCARD: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    beat_cnt_d = '0;
                    state_d    = COLLECT;
                end
            end
            OUTPUT: begin
                if (ready_i) begin
                    valid_d    = 1'b0;
                    beat_cnt_d = '0;
                    state_d    = COLLECT;
                end
            end
            default: begin
                valid_d    = 1'b0;
                beat_cnt_d = '0;
                state_d    = COLLECT;
            end
        endcase
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= COLLECT;
            beat_cnt_q  <= '0;
            beats_q     <= '0;
            cmd_q       <= '0;
            valid_q     <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            err_op_q    <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            beats_q     <= beats_d;
            cmd_q       <= cmd_d;
            valid_q     <= valid_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            err_op_q    <= err_op_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign s_axis_tready = (state_q == COLLECT) || (state_q == DISCARD);
    assign cmd_o         = cmd_q;
    assign valid_o       = valid_q;
    assign err_short_o   = err_short_q;
    assign err_long_o    = err_long_q;
    assign err_op_o      = err_op_q;
    assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_hash_cmd_deserializer.sv
// Directed bench for hash_cmd_deserializer with default parameters (37-bit command, two beats).
module tb_hash_cmd_deserializer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic [36:0] cmd_o;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic        err_short_o, err_long_o, err_op_o;
    logic [15:0] drop_cnt_o;

    int total = 0;
    int bad   = 0;
    int hs_cnt = 0;

    // Packet A: data DEADBEEF, op 010 (write), key 3 -> {01011, DEADBEEF}
    localparam logic [31:0] A_B0  = 32'hDEADBEEF;
    localparam logic [31:0] A_B1  = {27'b0, 3'b010, 2'b11};
    localparam logic [36:0] A_CMD = 37'h0B_DEADBEEF;
    // Packet B: data 12345678, op 100 (delete), key 1 -> {10001, 12345678}
    localparam logic [31:0] B_B0  = 32'h12345678;
    localparam logic [31:0] B_B1  = {27'b0, 3'b100, 2'b01};
    localparam logic [36:0] B_CMD = 37'h11_12345678;

    hash_cmd_deserializer dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .cmd_o         (cmd_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .err_short_o   (err_short_o),
        .err_long_o    (err_long_o),
        .err_op_o      (err_op_o),
        .drop_cnt_o    (drop_cnt_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (valid_o && ready_i) hs_cnt++;
    end

    task automatic do_reset();
        reset = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic l);
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = l;
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        total++;
        if (valid_o !== 1'b0 || cmd_o !== 37'h0 || drop_cnt_o !== 16'h0 ||
            err_short_o !== 1'b0 || err_long_o !== 1'b0 || err_op_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: valid=%b cmd=%h drop=%h errs=%b%b%b, want 0", valid_o, cmd_o,
                     drop_cnt_o, err_short_o, err_long_o, err_op_o);
        end
        do_reset();
        total++;
        if (s_axis_tready !== 1'b1) begin
            bad++;
            $display("FAIL reset_tready: got %b want 1", s_axis_tready);
        end
    endtask

    task automatic test_good_packet();
        int hs0;
        do_reset();
        ready_i = 1'b1;
        hs0 = hs_cnt;
        beat(A_B0, 1'b0);
        total++;
        if (valid_o !== 1'b0) begin
            bad++;
            $display("FAIL good_early_valid: got %b want 0", valid_o);
        end
        beat(A_B1, 1'b1);
        total++;
        if (valid_o !== 1'b1 || cmd_o !== A_CMD || s_axis_tready !== 1'b0) begin
            bad++;
            $display("FAIL good_cmd: valid=%b cmd=%h tready=%b want 1 %h 0", valid_o, cmd_o, s_axis_tready, A_CMD);
        end
        @(posedge clk); #1;
        total++;
        if (valid_o !== 1'b0 || s_axis_tready !== 1'b1 || hs_cnt - hs0 !== 1) begin
            bad++;
            $display("FAIL good_handshake: valid=%b tready=%b hs=%0d want 0 1 1", valid_o, s_axis_tready, hs_cnt - hs0);
        end
    endtask

    task automatic test_backpressure();
        int hs0;
        do_reset();
        ready_i = 1'b0;
        hs0 = hs_cnt;
        beat(A_B0, 1'b0);
        beat(A_B1, 1'b1);
        // Offer a competing beat during the stall; it must not be taken.
        s_axis_tdata  = B_B0;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (valid_o !== 1'b1 || cmd_o !== A_CMD || s_axis_tready !== 1'b0) begin
                bad++;
                $display("FAIL stall_cycle%0d: valid=%b cmd=%h tready=%b want 1 %h 0", i, valid_o, cmd_o,
                         s_axis_tready, A_CMD);
            end
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b0;
        ready_i = 1'b1;
        @(posedge clk); #1;
        total++;
        if (valid_o !== 1'b0 || s_axis_tready !== 1'b1 || hs_cnt - hs0 !== 1) begin
            bad++;
            $display("FAIL stall_release: valid=%b tready=%b hs=%0d want 0 1 1", valid_o, s_axis_tready, hs_cnt - hs0);
        end
        beat(B_B0, 1'b0);
        beat(B_B1, 1'b1);
        total++;
        if (valid_o !== 1'b1 || cmd_o !== B_CMD) begin
            bad++;
            $display("FAIL stall_next_cmd: valid=%b cmd=%h want 1 %h", valid_o, cmd_o, B_CMD);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_short();
        int hs0;
        do_reset();
        hs0 = hs_cnt;
        beat(A_B0, 1'b1);
        total++;
        if (err_short_o !== 1'b1 || drop_cnt_o !== 16'd1 || valid_o !== 1'b0 || err_long_o !== 1'b0) begin
            bad++;
            $display("FAIL short_detect: err_short=%b err_long=%b drop=%0d valid=%b want 1 0 1 0", err_short_o,
                     err_long_o, drop_cnt_o, valid_o);
        end
        @(posedge clk); #1;
        total++;
        if (err_short_o !== 1'b0) begin
            bad++;
            $display("FAIL short_pulse_width: got %b want 0", err_short_o);
        end
        beat(B_B0, 1'b0);
        beat(B_B1, 1'b1);
        total++;
        if (valid_o !== 1'b1 || cmd_o !== B_CMD || hs_cnt - hs0 !== 0) begin
            bad++;
            $display("FAIL short_then_good: valid=%b cmd=%h hs=%0d want 1 %h 0", valid_o, cmd_o, hs_cnt - hs0, B_CMD);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_long();
        int hs0;
        do_reset();
        hs0 = hs_cnt;
        beat(32'h1, 1'b0);
        beat(A_B1, 1'b0);
        total++;
        if (err_long_o !== 1'b1 || drop_cnt_o !== 16'd1 || s_axis_tready !== 1'b1 || valid_o !== 1'b0) begin
            bad++;
            $display("FAIL long_detect: err_long=%b drop=%0d tready=%b valid=%b want 1 1 1 0", err_long_o,
                     drop_cnt_o, s_axis_tready, valid_o);
        end
        beat(32'h3, 1'b0);
        total++;
        if (err_long_o !== 1'b0 || drop_cnt_o !== 16'd1) begin
            bad++;
            $display("FAIL long_swallow3: err_long=%b drop=%0d want 0 1", err_long_o, drop_cnt_o);
        end
        beat(A_B1, 1'b1);
        total++;
        if (valid_o !== 1'b0 || drop_cnt_o !== 16'd1 || err_short_o !== 1'b0 || err_op_o !== 1'b0) begin
            bad++;
            $display("FAIL long_swallow4: valid=%b drop=%0d errs=%b%b want 0 1 00", valid_o, drop_cnt_o,
                     err_short_o, err_op_o);
        end
        beat(A_B0, 1'b0);
        beat(A_B1, 1'b1);
        total++;
        if (valid_o !== 1'b1 || cmd_o !== A_CMD || hs_cnt - hs0 !== 0) begin
            bad++;
            $display("FAIL long_then_good: valid=%b cmd=%h hs=%0d want 1 %h 0", valid_o, cmd_o, hs_cnt - hs0, A_CMD);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_bad_op();
        do_reset();
        beat(A_B0, 1'b0);
        beat({27'b0, 3'b011, 2'b01}, 1'b1);
        total++;
        if (err_op_o !== 1'b1 || drop_cnt_o !== 16'd1 || valid_o !== 1'b0) begin
            bad++;
            $display("FAIL badop_011: err_op=%b drop=%0d valid=%b want 1 1 0", err_op_o, drop_cnt_o, valid_o);
        end
        beat(A_B0, 1'b0);
        beat({27'b0, 3'b000, 2'b10}, 1'b1);
        total++;
        if (err_op_o !== 1'b1 || drop_cnt_o !== 16'd2 || valid_o !== 1'b0) begin
            bad++;
            $display("FAIL badop_000: err_op=%b drop=%0d valid=%b want 1 2 0", err_op_o, drop_cnt_o, valid_o);
        end
        @(posedge clk); #1;
        total++;
        if (err_op_o !== 1'b0 || s_axis_tready !== 1'b1) begin
            bad++;
            $display("FAIL badop_recover: err_op=%b tready=%b want 0 1", err_op_o, s_axis_tready);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        beat(32'hFFFF_FFFF, 1'b0);
        do_reset();
        beat(B_B0, 1'b0);
        beat(B_B1, 1'b1);
        total++;
        if (valid_o !== 1'b1 || cmd_o !== B_CMD || drop_cnt_o !== 16'd0 || err_long_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_packet: valid=%b cmd=%h drop=%0d err_long=%b want 1 %h 0 0", valid_o, cmd_o,
                     drop_cnt_o, err_long_o, B_CMD);
        end
        ready_i = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        total++;
        if (valid_o !== 1'b0 || cmd_o !== 37'h0) begin
            bad++;
            $display("FAIL reset_mid_output: valid=%b cmd=%h want 0 0", valid_o, cmd_o);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        ready_i = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        do_reset();
        s_axis_tdata  = 32'h0;
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        total++;
        if (drop_cnt_o !== 16'hFFFE) begin
            bad++;
            $display("FAIL sat_fffe: got %h want fffe", drop_cnt_o);
        end
        @(posedge clk); #1;
        total++;
        if (drop_cnt_o !== 16'hFFFF) begin
            bad++;
            $display("FAIL sat_ffff: got %h want ffff", drop_cnt_o);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (drop_cnt_o !== 16'hFFFF || err_short_o !== 1'b1) begin
            bad++;
            $display("FAIL sat_hold: drop=%h err_short=%b want ffff 1", drop_cnt_o, err_short_o);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_backpressure();
        test_short();
        test_long();
        test_bad_op();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
